// File: rtl/leaf_out_packetizer_if.sv
// User-side output stream bundle: per-port payloads and valids toward the
// packetizer, one-hot accept pulses back to the kernel.
interface leaf_out_packetizer_if #(
  parameter int NUM_OUT_PORTS = 7,
  parameter int PAYLOAD_BITS  = 32
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/leaf_out_packetizer.sv
// Round-robin packetizer for N user output streams onto one BFT packet bus,
// with per-port destination tagging, address sequencing and credit flow control.
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  resend,
  leaf_out_packetizer_if.slave  user,
  input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic [NUM_OUT_PORTS-1:0] credit_return,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  output logic [NUM_OUT_PORTS-1:0] credit_empty
);

  localparam int DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int PTR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam int SUM_BITS    = CREDIT_BITS + $clog2(FREESPACE_UPDATE_SIZE + 1) + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(1) << NUM_BRAM_ADDR_BITS;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     grant_any;
  logic [PTR_BITS-1:0]      grant_idx;
  logic [PTR_BITS-1:0]      rr_ptr_reg;
  logic [PACKET_BITS-1:0]   packet_word [NUM_OUT_PORTS];
  logic [PACKET_BITS-1:0]   dout_reg;
  logic [PACKET_BITS-1:0]   dout_next;

  for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
    logic [CREDIT_BITS-1:0]   credit_reg;
    logic [CREDIT_BITS-1:0]   credit_next;
    logic [SUM_BITS-1:0]      credit_sum;
    logic [NUM_ADDR_BITS-1:0] addr_reg;
    logic                     empty_reg;

    assign eligible[gi] = user.vld_user2interface[gi] && (credit_reg != '0) && !resend && !reset;

    assign packet_word[gi] = {1'b1,
                              dest_cfg[gi*DEST_BITS +: DEST_BITS],
                              addr_reg,
                              user.din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS]};

    // A send only happens with credit > 0, so the subtraction cannot underflow.
    always_comb begin
      credit_sum = SUM_BITS'(credit_reg);
      if (credit_return[gi]) begin
        credit_sum = credit_sum + SUM_BITS'(FREESPACE_UPDATE_SIZE);
      end
      if (grant[gi]) begin
        credit_sum = credit_sum - SUM_BITS'(1);
      end
      credit_next = (credit_sum > SUM_BITS'(CREDIT_MAX)) ? CREDIT_MAX
                                                          : credit_sum[CREDIT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        credit_reg <= CREDIT_MAX;
        addr_reg   <= '0;
        empty_reg  <= 1'b0;
      end else begin
        credit_reg <= credit_next;
        empty_reg  <= (credit_next == '0);
        if (grant[gi]) begin
          addr_reg <= addr_reg + 1'b1;
        end
      end
    end

    assign credit_empty[gi] = empty_reg;
  end

  // Search starts just after the last granted port, wrapping around.
  always_comb begin
    int                  idx;
    logic [PTR_BITS-1:0] cand;
    idx       = 0;
    cand      = '0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = rr_ptr_reg;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_OUT_PORTS) begin
        idx = idx - NUM_OUT_PORTS;
      end
      cand = PTR_BITS'(idx);
      if (!grant_any && eligible[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign dout_next = grant_any ? packet_word[grant_idx] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= PTR_BITS'(NUM_OUT_PORTS - 1);
      dout_reg   <= '0;
    end else begin
      dout_reg <= dout_next;
      if (grant_any) begin
        rr_ptr_reg <= grant_idx;
      end
    end
  end

  assign user.ack_interface2user = grant;
  // resend masks the registered word without disturbing it.
  assign dout_leaf_interface2bft = resend ? '0 : dout_reg;

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Randomized and directed bench for leaf_out_packetizer against a
// cycle-level reference model of arbitration, credits and addressing.
module tb_leaf_out_packetizer;
  localparam int N   = 7;
  localparam int PB  = 49;
  localparam int CAP = 128;
  localparam int UPD = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              resend;
  logic [N*9-1:0]    dest_cfg;
  logic [N-1:0]      credit_return;
  logic [PB-1:0]     dout;
  logic [N-1:0]      credit_empty;
  logic [N-1:0]      vld;
  logic [31:0]       pay [N];
  int                dest_leaf [N];
  int                dest_port [N];

  leaf_out_packetizer_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(32)) uif ();

  leaf_out_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .resend                  (resend),
    .user                    (uif),
    .dest_cfg                (dest_cfg),
    .credit_return           (credit_return),
    .dout_leaf_interface2bft (dout),
    .credit_empty            (credit_empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    uif.din_leaf_user2interface = '0;
    for (int i = 0; i < N; i++) uif.din_leaf_user2interface[i*32 +: 32] = pay[i];
  end
  assign uif.vld_user2interface = vld;

  // Reference model state
  int            m_credit [N];
  int            m_addr   [N];
  int            m_rr;
  logic [PB-1:0] m_dout;
  logic [N-1:0]  m_empty;
  int            ack_cnt  [N];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_credit[i] = CAP;
      m_addr[i]   = 0;
    end
    m_rr    = N - 1;
    m_dout  = '0;
    m_empty = '0;
  endfunction

  // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    int           g;
    int           c;
    logic [N-1:0] exp_ack;
    #3;
    g = -1;
    if (!resend && !reset) begin
      for (int k = 1; k <= N; k++) begin
        int idx = (m_rr + k) % N;
        if (g < 0 && vld[idx] && m_credit[idx] > 0) g = idx;
      end
    end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check_eq("ack", uif.ack_interface2user, exp_ack);
    check_eq("dout", dout, resend ? '0 : m_dout);
    check_eq("credit_empty", credit_empty, m_empty);
    for (int i = 0; i < N; i++) if (uif.ack_interface2user[i]) ack_cnt[i]++;
    if (dout[PB-1])
      $display("pkt t=%0t leaf=%0d port=%0d addr=%0d data=%08h",
               $time, dout[47:43], dout[42:39], dout[38:32], dout[31:0]);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        m_dout    = {1'b1, 5'(dest_leaf[g]), 4'(dest_port[g]), 7'(m_addr[g]), pay[g]};
        m_addr[g] = (m_addr[g] + 1) % 128;
        m_rr      = g;
      end else begin
        m_dout = '0;
      end
      for (int i = 0; i < N; i++) begin
        c = m_credit[i] + (credit_return[i] ? UPD : 0) - ((g == i) ? 1 : 0);
        if (c > CAP) c = CAP;
        m_credit[i] = c;
        m_empty[i]  = (c == 0);
      end
    end
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) ack_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; resend = 1'b0; credit_return = '0; vld = '0;
    for (int i = 0; i < N; i++) begin
      pay[i]       = $urandom;
      dest_leaf[i] = (i == 0) ? 3 : int'($urandom_range(0, 31));
      dest_port[i] = (i == 0) ? 2 : int'($urandom_range(0, 15));
      dest_cfg[i*9 +: 9] = {5'(dest_leaf[i]), 4'(dest_port[i])};
    end
    clear_counts();
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    vld = '1;
    tick();               // reset still high: no acks, outputs at reset values
    reset = 1'b0;
    vld = '0;

    // Port 0 alone
    vld[0] = 1'b1; pay[0] = 32'hA5A5_0001;
    tick();
    check_eq("tp1_word0", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5_0001});
    tick();
    check_eq("tp1_word1", dout, {1'b1, 5'd3, 4'd2, 7'd1, 32'hA5A5_0001});
    vld = '0;

    // All ports for 14 cycles: fairness
    clear_counts();
    vld = '1;
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) pay[i] = $urandom;
      tick();
    end
    for (int i = 0; i < N; i++) check_eq($sformatf("fair_p%0d", i), ack_cnt[i], 2);
    vld = '0;

    // Port 2 drains its credit, then one return
    do_reset();
    clear_counts();
    vld[2] = 1'b1;
    for (int c = 0; c < 135; c++) begin pay[2] = $urandom; tick(); end
    check_eq("drain_acks", ack_cnt[2], 128);
    check_eq("drain_empty", credit_empty[2], 1);
    credit_return[2] = 1'b1;
    tick();
    credit_return[2] = 1'b0;
    tick();
    check_eq("return_ack", ack_cnt[2], 129);
    vld = '0;

    // Return at full credit saturates; return coincident with a send at credit 1
    credit_return[5] = 1'b1; tick(); credit_return[5] = 1'b0;
    vld[2] = 1'b1;
    for (int c = 0; c < 100 && m_credit[2] > 1; c++) tick();
    credit_return[2] = 1'b1; tick(); credit_return[2] = 1'b0;
    clear_counts();
    for (int c = 0; c < 70; c++) tick();
    check_eq("coincident_acks", ack_cnt[2], 64);
    check_eq("coincident_empty", credit_empty[2], 1);
    vld = '0;

    // resend freezes everything
    do_reset();
    vld = '1;
    tick(); tick();
    clear_counts();
    resend = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check_eq("resend_acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] + ack_cnt[4]
                            + ack_cnt[5] + ack_cnt[6], 0);
    resend = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    vld = '0;

    // Address wrap on port 1, then reset mid-stream
    do_reset();
    clear_counts();
    vld[1] = 1'b1;
    for (int c = 0; c < 300 && ack_cnt[1] < 130; c++) begin
      pay[1] = $urandom;
      credit_return[1] = (c % 40 == 39);
      tick();
    end
    credit_return = '0;
    check_eq("wrap_count", ack_cnt[1], 130);
    check_eq("wrap_addr", dout[38:32], 1);
    reset = 1'b1;
    tick();
    check_eq("reset_dout", dout, 0);
    reset = 1'b0;
    tick();
    check_eq("post_reset_valid", dout[48], 1);
    check_eq("post_reset_addr", dout[38:32], 0);
    vld = '0;

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      vld           = N'($urandom);
      for (int i = 0; i < N; i++) pay[i] = $urandom;
      for (int i = 0; i < N; i++) credit_return[i] = ($urandom_range(0, 15) == 0);
      resend        = ($urandom_range(0, 19) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; resend = 1'b0; vld = '0; credit_return = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
